// File: rtl/com_bus_arbiter_if.sv
// Common-bus request/grant bundle between the requesters (master) and the arbiter (slave).
interface com_bus_arbiter_if #(
   parameter int NUM_REQ = 8
);
   logic [NUM_REQ-1:0] Com_Bus_Req_proc;
   logic [NUM_REQ-1:0] Com_Bus_Req_snoop;
   logic               Mem_snoop_req;
   logic [NUM_REQ-1:0] Com_Bus_Gnt_proc;
   logic [NUM_REQ-1:0] Com_Bus_Gnt_snoop;
   logic               Mem_snoop_gnt;
   logic               bus_busy;
   logic               hold_timeout;

   modport master (
      output Com_Bus_Req_proc, Com_Bus_Req_snoop, Mem_snoop_req,
      input  Com_Bus_Gnt_proc, Com_Bus_Gnt_snoop, Mem_snoop_gnt, bus_busy, hold_timeout
   );

   modport slave (
      input  Com_Bus_Req_proc, Com_Bus_Req_snoop, Mem_snoop_req,
      output Com_Bus_Gnt_proc, Com_Bus_Gnt_snoop, Mem_snoop_gnt, bus_busy, hold_timeout
   );
endinterface

// File: rtl/com_bus_arbiter.sv
// Common-bus arbiter (snoop > memory > round-robin proc, nested snoop flush); grants 1 cycle after request.
// Level requests: a grant is held while its request stays high and drops on the edge it is seen low.
module com_bus_arbiter #(
   parameter int NUM_REQ  = 8,
   parameter int MAX_HOLD = 256,
   parameter int CNT_W    = 9
) (
   input logic              clk,
   input logic              rst,
   com_bus_arbiter_if.slave bus
);
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [2:0] {IDLE, PROC, PROC_SNP, SNOOP, MEM} state_t;

   state_t             state;
   logic [IW-1:0]      rr_ptr;
   logic [IW-1:0]      p_idx;
   logic [IW-1:0]      s_idx;
   logic               proc_done;
   logic [CNT_W-1:0]   hold_cnt;
   logic [NUM_REQ-1:0] gnt_proc;
   logic [NUM_REQ-1:0] gnt_snoop;
   logic               mem_gnt;
   logic               busy;
   logic               timeout;

   logic               snp_any;
   logic [IW-1:0]      snp_first;
   logic               nest_any;
   logic [IW-1:0]      nest_first;
   logic               rr_any;
   logic [IW-1:0]      rr_pick;
   logic [IW-1:0]      rr_idx;
   logic [IW-1:0]      rr_next;

   // Descending scans so the lowest index (or the first slot after rr_ptr) wins.
   always_comb begin
      snp_any    = 1'b0;
      snp_first  = '0;
      nest_any   = 1'b0;
      nest_first = '0;
      rr_any     = 1'b0;
      rr_pick    = '0;
      rr_idx     = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (bus.Com_Bus_Req_snoop[i]) begin
            snp_any   = 1'b1;
            snp_first = IW'(i);
         end
         if (bus.Com_Bus_Req_snoop[i] && (IW'(i) != p_idx)) begin
            nest_any   = 1'b1;
            nest_first = IW'(i);
         end
         rr_idx = IW'((int'(rr_ptr) + i) % NUM_REQ);
         if (bus.Com_Bus_Req_proc[rr_idx]) begin
            rr_any  = 1'b1;
            rr_pick = rr_idx;
         end
      end
   end

   assign rr_next = IW'((int'(p_idx) + 1) % NUM_REQ);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         p_idx     <= '0;
         s_idx     <= '0;
         proc_done <= 1'b0;
         hold_cnt  <= '0;
         gnt_proc  <= '0;
         gnt_snoop <= '0;
         mem_gnt   <= 1'b0;
         busy      <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         // Watchdog: any branch below that changes the grant set clears hold_cnt.
         if (busy) begin
            if (hold_cnt != CNT_W'(MAX_HOLD)) hold_cnt <= hold_cnt + 1'b1;
            if (hold_cnt == CNT_W'(MAX_HOLD - 1)) timeout <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (snp_any) begin
                  state     <= SNOOP;
                  s_idx     <= snp_first;
                  gnt_snoop <= NUM_REQ'(1) << snp_first;
                  busy      <= 1'b1;
               end else if (bus.Mem_snoop_req) begin
                  state   <= MEM;
                  mem_gnt <= 1'b1;
                  busy    <= 1'b1;
               end else if (rr_any) begin
                  state    <= PROC;
                  p_idx    <= rr_pick;
                  gnt_proc <= NUM_REQ'(1) << rr_pick;
                  busy     <= 1'b1;
               end
            end
            PROC: begin
               if (!bus.Com_Bus_Req_proc[p_idx]) begin
                  state    <= IDLE;
                  gnt_proc <= '0;
                  busy     <= 1'b0;
                  rr_ptr   <= rr_next;
                  hold_cnt <= '0;
               end else if (nest_any) begin
                  state     <= PROC_SNP;
                  s_idx     <= nest_first;
                  gnt_snoop <= NUM_REQ'(1) << nest_first;
                  hold_cnt  <= '0;
               end
            end
            PROC_SNP: begin
               if (!bus.Com_Bus_Req_snoop[s_idx]) begin
                  gnt_snoop <= '0;
                  proc_done <= 1'b0;
                  hold_cnt  <= '0;
                  if (proc_done || !bus.Com_Bus_Req_proc[p_idx]) begin
                     state    <= IDLE;
                     gnt_proc <= '0;
                     busy     <= 1'b0;
                     rr_ptr   <= rr_next;
                  end else begin
                     state <= PROC;
                  end
               end else if (!bus.Com_Bus_Req_proc[p_idx]) begin
                  proc_done <= 1'b1;
               end
            end
            SNOOP: begin
               if (!bus.Com_Bus_Req_snoop[s_idx]) begin
                  state     <= IDLE;
                  gnt_snoop <= '0;
                  busy      <= 1'b0;
                  hold_cnt  <= '0;
               end
            end
            MEM: begin
               if (!bus.Mem_snoop_req) begin
                  state    <= IDLE;
                  mem_gnt  <= 1'b0;
                  busy     <= 1'b0;
                  hold_cnt <= '0;
               end
            end
            default: begin
               state     <= IDLE;
               gnt_proc  <= '0;
               gnt_snoop <= '0;
               mem_gnt   <= 1'b0;
               busy      <= 1'b0;
               hold_cnt  <= '0;
            end
         endcase
      end
   end

   assign bus.Com_Bus_Gnt_proc  = gnt_proc;
   assign bus.Com_Bus_Gnt_snoop = gnt_snoop;
   assign bus.Mem_snoop_gnt     = mem_gnt;
   assign bus.bus_busy          = busy;
   assign bus.hold_timeout      = timeout;
endmodule

// File: tb/tb_com_bus_arbiter.sv
// Bench for com_bus_arbiter: directed scenarios then random requests, all checked against a reference model.
module tb_com_bus_arbiter;
   localparam int N    = 8;
   localparam int MAXH = 8;

   logic clk;
   logic rst;
   int   errors;
   int   checks;

   // Reference model: current owners as indices (-1 = none) plus pointer and watchdog.
   int   m_p;
   int   m_s;
   bit   m_m;
   bit   m_done;
   int   m_rr;
   int   m_cnt;
   bit   m_to;

   com_bus_arbiter_if #(.NUM_REQ(N)) bus ();

   com_bus_arbiter #(.NUM_REQ(N), .MAX_HOLD(MAXH), .CNT_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bit bit_at(logic [7:0] v, int i);
      logic [2:0] k;
      k = i[2:0];
      return v[k];
   endfunction

   function automatic int lowest(logic [7:0] v, int excl);
      int r;
      r = -1;
      for (int i = N - 1; i >= 0; i--) if (bit_at(v, i) && i != excl) r = i;
      return r;
   endfunction

   function automatic int rr_search(logic [7:0] v, int start);
      int r;
      r = -1;
      for (int k = N - 1; k >= 0; k--) if (bit_at(v, (start + k) % N)) r = (start + k) % N;
      return r;
   endfunction

   function automatic logic [7:0] oh(int i);
      return (i < 0) ? 8'h00 : (8'h01 << i);
   endfunction

   function automatic logic [7:0] rmask(int odds);
      logic [7:0] m;
      m = 8'h00;
      for (int b = 0; b < N; b++) if ($urandom_range(0, odds - 1) == 0) m = m | (8'h01 << b);
      return m;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_step();
      int np, ns, nrr;
      bit nm, nd, busy, chg;
      logic [7:0] rp, rs;
      rp = bus.Com_Bus_Req_proc;
      rs = bus.Com_Bus_Req_snoop;
      if (rst) begin
         m_p = -1; m_s = -1; m_m = 0; m_done = 0; m_rr = 0; m_cnt = 0; m_to = 0;
         return;
      end
      busy = (m_p >= 0) || (m_s >= 0) || m_m;
      np = m_p; ns = m_s; nm = m_m; nd = m_done; nrr = m_rr;
      if (!busy) begin
         ns = lowest(rs, -1);
         if (ns < 0) begin
            if (bus.Mem_snoop_req) nm = 1;
            else np = rr_search(rp, m_rr);
         end
      end else if (m_m) begin
         if (!bus.Mem_snoop_req) nm = 0;
      end else if (m_p < 0) begin
         if (!bit_at(rs, m_s)) ns = -1;
      end else if (m_s < 0) begin
         if (!bit_at(rp, m_p)) begin
            np = -1;
            nrr = (m_p + 1) % N;
         end else begin
            ns = lowest(rs, m_p);
         end
      end else if (!bit_at(rs, m_s)) begin
         ns = -1;
         nd = 0;
         if (m_done || !bit_at(rp, m_p)) begin
            np = -1;
            nrr = (m_p + 1) % N;
         end
      end else if (!bit_at(rp, m_p)) begin
         nd = 1;
      end
      chg = (np != m_p) || (ns != m_s) || (nm != m_m);
      // A grant that has been up for MAXH cycles trips the sticky flag.
      if (busy && m_cnt == MAXH - 1) m_to = 1;
      if (chg) m_cnt = 0;
      else if (busy && m_cnt < MAXH) m_cnt++;
      m_p = np; m_s = ns; m_m = nm; m_done = nd; m_rr = nrr;
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
      chk("gnt_proc", 32'(bus.Com_Bus_Gnt_proc), 32'(oh(m_p)));
      chk("gnt_snoop", 32'(bus.Com_Bus_Gnt_snoop), 32'(oh(m_s)));
      chk("mem_gnt", 32'(bus.Mem_snoop_gnt), 32'(m_m));
      chk("bus_busy", 32'(bus.bus_busy), 32'((m_p >= 0) || (m_s >= 0) || m_m));
      chk("hold_timeout", 32'(bus.hold_timeout), 32'(m_to));
   endtask

   initial begin
      int seq [3];
      errors = 0;
      checks = 0;
      m_p = -1; m_s = -1; m_m = 0; m_done = 0; m_rr = 0; m_cnt = 0; m_to = 0;
      seq = '{1, 7, 1};

      // Reset with every request high, then snoop 0 wins first.
      rst = 1'b1;
      bus.Com_Bus_Req_proc  = 8'hFF;
      bus.Com_Bus_Req_snoop = 8'hFF;
      bus.Mem_snoop_req     = 1'b1;
      repeat (2) begin
         cyc();
         chk("t1_rst_gp", 32'(bus.Com_Bus_Gnt_proc), 32'h0);
         chk("t1_rst_gs", 32'(bus.Com_Bus_Gnt_snoop), 32'h0);
         chk("t1_rst_busy", 32'(bus.bus_busy), 32'h0);
      end
      rst = 1'b0;
      cyc();
      chk("t1_first_snoop", 32'(bus.Com_Bus_Gnt_snoop), 32'h01);
      bus.Com_Bus_Req_proc  = 8'h00;
      bus.Com_Bus_Req_snoop = 8'h00;
      bus.Mem_snoop_req     = 1'b0;
      cyc();
      chk("t1_release", 32'(bus.Com_Bus_Gnt_snoop), 32'h0);

      // Round robin between idx1 and idx7 with one dead cycle between grants.
      bus.Com_Bus_Req_proc = 8'h82;
      for (int n = 0; n < 3; n++) begin
         cyc();
         chk("t2_gnt", 32'(bus.Com_Bus_Gnt_proc), 32'(oh(seq[n])));
         repeat (2) begin
            cyc();
            chk("t2_hold", 32'(bus.Com_Bus_Gnt_proc), 32'(oh(seq[n])));
         end
         bus.Com_Bus_Req_proc = bus.Com_Bus_Req_proc & ~oh(seq[n]);
         cyc();
         chk("t2_idle", 32'(bus.Com_Bus_Gnt_proc), 32'h0);
         bus.Com_Bus_Req_proc = (n < 2) ? 8'h82 : 8'h00;
      end

      // Nested snoop flush under proc 2, then proc falls before the snoop.
      bus.Com_Bus_Req_proc = 8'h04;
      cyc();
      chk("t3_proc", 32'(bus.Com_Bus_Gnt_proc), 32'h04);
      bus.Com_Bus_Req_snoop = 8'h01;
      cyc();
      chk("t3_nest_gs", 32'(bus.Com_Bus_Gnt_snoop), 32'h01);
      chk("t3_nest_gp", 32'(bus.Com_Bus_Gnt_proc), 32'h04);
      bus.Com_Bus_Req_snoop = 8'h00;
      cyc();
      chk("t3_unnest_gs", 32'(bus.Com_Bus_Gnt_snoop), 32'h0);
      chk("t3_unnest_gp", 32'(bus.Com_Bus_Gnt_proc), 32'h04);
      bus.Com_Bus_Req_snoop = 8'h10;
      cyc();
      chk("t3_nest2_gs", 32'(bus.Com_Bus_Gnt_snoop), 32'h10);
      bus.Com_Bus_Req_proc = 8'h00;
      cyc();
      chk("t3_keep_gp", 32'(bus.Com_Bus_Gnt_proc), 32'h04);
      bus.Com_Bus_Req_snoop = 8'h00;
      cyc();
      chk("t3_both_drop", 32'({bus.Com_Bus_Gnt_proc, bus.Com_Bus_Gnt_snoop}), 32'h0);

      // Memory beats proc; snoop self-request is held off until IDLE.
      bus.Mem_snoop_req    = 1'b1;
      bus.Com_Bus_Req_proc = 8'h08;
      cyc();
      chk("t4_mem", 32'(bus.Mem_snoop_gnt), 32'h1);
      chk("t4_mem_gp", 32'(bus.Com_Bus_Gnt_proc), 32'h0);
      cyc();
      bus.Mem_snoop_req = 1'b0;
      cyc();
      chk("t4_mem_rel", 32'(bus.Mem_snoop_gnt), 32'h0);
      cyc();
      chk("t4_proc3", 32'(bus.Com_Bus_Gnt_proc), 32'h08);
      bus.Com_Bus_Req_snoop = 8'h08;
      cyc();
      chk("t4_self_held", 32'(bus.Com_Bus_Gnt_snoop), 32'h0);
      bus.Com_Bus_Req_proc = 8'h00;
      cyc();
      chk("t4_idle", 32'(bus.bus_busy), 32'h0);
      cyc();
      chk("t4_self_gnt", 32'(bus.Com_Bus_Gnt_snoop), 32'h08);
      bus.Com_Bus_Req_snoop = 8'h00;
      cyc();

      // Watchdog fires 8 cycles after the grant and is sticky until reset.
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      bus.Com_Bus_Req_proc = 8'h20;
      cyc();
      chk("t5_gnt", 32'(bus.Com_Bus_Gnt_proc), 32'h20);
      for (int k = 1; k < MAXH; k++) begin
         cyc();
         chk("t5_not_yet", 32'(bus.hold_timeout), 32'h0);
      end
      cyc();
      chk("t5_fire", 32'(bus.hold_timeout), 32'h1);
      repeat (11) cyc();
      bus.Com_Bus_Req_proc = 8'h00;
      cyc();
      chk("t5_rel_gp", 32'(bus.Com_Bus_Gnt_proc), 32'h0);
      cyc();
      chk("t5_sticky", 32'(bus.hold_timeout), 32'h1);
      rst = 1'b1;
      cyc();
      chk("t5_rst_clear", 32'(bus.hold_timeout), 32'h0);
      rst = 1'b0;

      // Reset during a nested flush aborts both grants and rewinds the pointer.
      bus.Com_Bus_Req_proc = 8'h01;
      cyc();
      bus.Com_Bus_Req_proc = 8'h00;
      cyc();
      bus.Com_Bus_Req_proc = 8'h40;
      cyc();
      chk("t6_gp", 32'(bus.Com_Bus_Gnt_proc), 32'h40);
      bus.Com_Bus_Req_snoop = 8'h02;
      cyc();
      chk("t6_gs", 32'(bus.Com_Bus_Gnt_snoop), 32'h02);
      rst = 1'b1;
      cyc();
      chk("t6_rst_gp", 32'(bus.Com_Bus_Gnt_proc), 32'h0);
      chk("t6_rst_gs", 32'(bus.Com_Bus_Gnt_snoop), 32'h0);
      chk("t6_rr_ptr", 32'(dut.rr_ptr), 32'h0);
      rst = 1'b0;
      bus.Com_Bus_Req_proc  = 8'h00;
      bus.Com_Bus_Req_snoop = 8'h00;
      cyc();

      // Random request traffic with occasional resets.
      for (int c = 0; c < 1500; c++) begin
         rst = ($urandom_range(0, 199) == 0);
         bus.Com_Bus_Req_proc  = bus.Com_Bus_Req_proc ^ rmask(6);
         bus.Com_Bus_Req_snoop = bus.Com_Bus_Req_snoop ^ rmask(12);
         if ($urandom_range(0, 9) == 0) bus.Mem_snoop_req = ~bus.Mem_snoop_req;
         cyc();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
